imem_loader: RTL and testbench

//  Program loader on the write side of the instruction memory. Receives a byte

---
 rtl/imem_loader.sv | 115 +++++++++++
 tb/tb_imem_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory program loader: packs a little-endian byte stream into
// 32-bit words, writes them to imem, zero-fills the rest and releases the CPU.
module imem_loader #(
    parameter int N      = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [N-1:0]      wdata,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        FILL  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [N-1:0]      wdata_q, wdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W:0]   lenc_q, lenc_d;
    logic [ADDR_W:0]   lenc_m1;

    assign lenc_m1 = lenc_q - 1'b1;

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        lenc_d  = lenc_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    lenc_d  = (len > LEN_MAX) ? LEN_MAX : len;
                    waddr_d = '0;
                    wdata_d = '0;
                    cnt_d   = '0;
                    state_d = (len == '0) ? FILL : RECV;
                end
            end
            RECV: begin
                if (byte_valid) begin
                    wdata_d[8*cnt_q +: 8] = byte_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = WRITE;
                end
            end
            WRITE: begin
                cnt_d = '0;
                if ({1'b0, waddr_q} == lenc_m1) begin
                    // A full-depth program needs no zero fill.
                    if (lenc_q == LEN_MAX) begin
                        state_d = DONE;
                    end else begin
                        waddr_d = waddr_q + 1'b1;
                        wdata_d = '0;
                        state_d = FILL;
                    end
                end else begin
                    waddr_d = waddr_q + 1'b1;
                    state_d = RECV;
                end
            end
            FILL: begin
                if (waddr_q == ADDR_LAST) state_d = DONE;
                else                      waddr_d = waddr_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            lenc_q  <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            lenc_q  <= lenc_d;
        end
    end

    // Every output is a pure decode of registered state.
    assign byte_ready = (state_q == RECV);
    assign we         = (state_q == WRITE) || (state_q == FILL);
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign busy       = (state_q == RECV) || (state_q == WRITE) || (state_q == FILL);
    assign done       = (state_q == DONE);
    assign cpu_hold   = (state_q != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: loads push expected writes, a negedge
// monitor pops and compares every imem write.
module tb_imem_loader;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;
    logic              byte_ready, we, busy, done, cpu_hold;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;

    imem_loader #(.N(32), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .we(we), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    wr_t         sb[$];
    logic [31:0] img[DEPTH];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (we) begin
            wr_t e;
            wr_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write", waddr, wdata);
            end else begin
                e = sb.pop_front();
                chk("waddr", {26'd0, waddr}, {26'd0, e.a});
                chk("wdata", wdata, e.d);
            end
        end
    end

    task automatic push_exp(input int neff);
        for (int i = 0; i < DEPTH; i++) begin
            wr_t e;
            e.a = ADDR_W'(i);
            e.d = (i < neff) ? img[i] : 32'd0;
            sb.push_back(e);
        end
    endtask

    task automatic do_start(input int l, input bit expect_go);
        if (expect_go) wr_cnt = 0;
        start = 1'b1;
        len   = (ADDR_W+1)'(l);
        @(posedge clk); #1;
        start = 1'b0;
        if (expect_go) begin
            chk("start_busy", {31'd0, busy}, 32'd1);
            chk("start_done", {31'd0, done}, 32'd0);
            chk("start_hold", {31'd0, cpu_hold}, 32'd1);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit ok = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (byte_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_timeout: got no byte_ready expected handshake for %h", b);
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic wait_done(input int budget);
        bit ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_in_budget", {31'd0, ok}, 32'd1);
        chk("done", {31'd0, done}, 32'd1);
        chk("cpu_hold_released", {31'd0, cpu_hold}, 32'd0);
        chk("busy_clear", {31'd0, busy}, 32'd0);
        chk("write_count", wr_cnt, DEPTH);
        chk("sb_empty", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_waddr", {26'd0, waddr}, 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Two-word program, back-to-back bytes
        img[0] = 32'hf800_0001;
        img[1] = 32'hf800_8002;
        push_exp(2);
        do_start(2, 1'b1);
        send_word(img[0], 1'b0);
        send_word(img[1], 1'b0);
        wait_done(100);

        // Same program with gaps, restarted from DONE
        push_exp(2);
        do_start(2, 1'b1);
        send_word(img[0], 1'b1);
        send_word(img[1], 1'b1);
        wait_done(100);

        // Full-depth program: done right after the 64th write
        for (int i = 0; i < DEPTH; i++) img[i] = i;
        push_exp(DEPTH);
        do_start(DEPTH, 1'b1);
        for (int i = 0; i < DEPTH; i++) send_word(img[i], 1'b0);
        wait_done(3);

        // Empty program and clamped length
        push_exp(0);
        do_start(0, 1'b1);
        wait_done(80);
        push_exp(DEPTH);
        do_start(100, 1'b1);
        for (int i = 0; i < DEPTH; i++) send_word(img[i], 1'b0);
        wait_done(3);

        // Reset mid-word: no write, back to IDLE with CPU held
        do_start(2, 1'b1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        reset = 1'b0;
        #1;
        chk("midrst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("midrst_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("midrst_we", {31'd0, we}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (5) @(posedge clk);
        chk("midrst_no_write", wr_cnt, 0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_hold", {31'd0, cpu_hold}, 32'd1);

        // Start pulses while busy are ignored
        img[0] = 32'hf800_0001;
        img[1] = 32'hf800_8002;
        push_exp(2);
        do_start(2, 1'b1);
        send_word(img[0], 1'b0);
        do_start(5, 1'b0);
        chk("ignored_start_busy", {31'd0, busy}, 32'd1);
        send_word(img[1], 1'b0);
        repeat (3) @(posedge clk);
        #1;
        do_start(0, 1'b0);
        wait_done(80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
